// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one execute ALU between two requesters, owns status register
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] val1_0,
    input  logic [31:0] val2_0,
    input  logic [31:0] val1_1,
    input  logic [31:0] val2_1,
    input  logic [3:0]  cmd_0,
    input  logic [3:0]  cmd_1,
    input  logic        s_0,
    input  logic        s_1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] result0,
    output logic [31:0] result1,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic [3:0]  alu_cmd,
    output logic        alu_cin,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_sr,
    output logic [3:0]  sr,
    output logic [1:0]  grant
);

    logic ptr;
    logic elig0;
    logic elig1;

    // A request is not eligible in its own ack cycle, so a held req is never granted twice.
    assign elig0 = req0 && !ack0;
    assign elig1 = req1 && !ack1;

    always_comb begin
        grant = 2'b00;
        if (!flush) begin
            if (elig0 && elig1) begin
                grant = ptr ? 2'b10 : 2'b01;
            end else begin
                grant = {elig1, elig0};
            end
        end
    end

    always_comb begin
        alu_val1 = 32'd0;
        alu_val2 = 32'd0;
        alu_cmd  = cmd_0;
        if (grant[0]) begin
            alu_val1 = val1_0;
            alu_val2 = val2_0;
            alu_cmd  = cmd_0;
        end else if (grant[1]) begin
            alu_val1 = val1_1;
            alu_val2 = val2_1;
            alu_cmd  = cmd_1;
        end
    end

    // Carry chains across ports: whichever op last set flags supplies the next carry-in.
    assign alu_cin = sr[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            result0 <= 32'd0;
            result1 <= 32'd0;
            sr      <= 4'b0000;
            ptr     <= 1'b0;
        end else begin
            ack0 <= grant[0];
            ack1 <= grant[1];
            if (grant[0]) begin
                result0 <= alu_result;
                ptr     <= 1'b1;
                if (s_0) begin
                    sr <= alu_sr;
                end
            end
            if (grant[1]) begin
                result1 <= alu_result;
                ptr     <= 1'b0;
                if (s_1) begin
                    sr <= alu_sr;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vector table plus randomized run against a transaction-level model
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush, req0, req1, s_0, s_1;
    logic [31:0] val1_0, val2_0, val1_1, val2_1;
    logic [3:0]  cmd_0, cmd_1;
    logic        ack0, ack1, alu_cin;
    logic [31:0] result0, result1, alu_val1, alu_val2, alu_result;
    logic [3:0]  alu_cmd, alu_sr, sr;
    logic [1:0]  grant;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] ADD = 4'd0, ADC = 4'd1, SUB = 4'd2;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush), .req0(req0), .req1(req1),
        .val1_0(val1_0), .val2_0(val2_0), .val1_1(val1_1), .val2_1(val2_1),
        .cmd_0(cmd_0), .cmd_1(cmd_1), .s_0(s_0), .s_1(s_1),
        .ack0(ack0), .ack1(ack1), .result0(result0), .result1(result1),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cmd(alu_cmd), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_sr(alu_sr), .sr(sr), .grant(grant)
    );

    // Reference ALU: returns {Z,C,N,V, result}
    function automatic logic [35:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        logic [32:0] w;
        logic        cy, v;
        w  = 33'd0;
        cy = 1'b0;
        v  = 1'b0;
        case (c)
            ADD: begin
                w = {1'b0, a} + {1'b0, b};
                cy = w[32];
                v = (a[31] == b[31]) && (w[31] != a[31]);
            end
            ADC: begin
                w = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                cy = w[32];
                v = (a[31] == b[31]) && (w[31] != a[31]);
            end
            SUB: begin
                w = {1'b0, a - b};
                cy = (a >= b);
                v = (a[31] != b[31]) && (w[31] != a[31]);
            end
            4'd3:    w = {1'b0, a & b};
            default: w = {1'b0, a ^ b};
        endcase
        return {(w[31:0] == 32'd0), cy, w[31], v, w[31:0]};
    endfunction

    always_comb {alu_sr, alu_result} = alu_ref(alu_cmd, alu_val1, alu_val2, alu_cin);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, flush, r0, r1, s0, s1;
        logic [3:0]  c0, c1;
        logic [31:0] a0, b0, a1, b1;
        logic [1:0]  eg;
        logic        ea0, ea1;
        logic [31:0] er0, er1;
        logic [3:0]  esr;
    } vec_t;

    function automatic vec_t mk(input logic rs, input logic fl, input logic r0, input logic r1,
                                input logic s0, input logic s1, input logic [3:0] c0,
                                input logic [3:0] c1, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] eg,
                                input logic ea0, input logic ea1, input logic [31:0] er0,
                                input logic [31:0] er1, input logic [3:0] esr);
        vec_t v;
        v.rst = rs; v.flush = fl; v.r0 = r0; v.r1 = r1; v.s0 = s0; v.s1 = s1;
        v.c0 = c0; v.c1 = c1; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
        v.eg = eg; v.ea0 = ea0; v.ea1 = ea1; v.er0 = er0; v.er1 = er1; v.esr = esr;
        return v;
    endfunction

    vec_t vt[19];

    logic        act[2];
    logic [3:0]  opc[2];
    logic [31:0] opa[2], opb[2];
    logic        ops[2];
    logic        m_ack[2];
    logic [31:0] m_res[2];
    logic [3:0]  m_sr;
    logic        m_ptr;

    task automatic new_op(input int i);
        act[i] = 1'b1;
        opc[i] = 4'($urandom_range(0, 4));
        opa[i] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
        opb[i] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
        ops[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [3:0]  prev_sr;
        logic [1:0]  eg;
        logic [35:0] fr;
        int          win;

        // rst flush r0 r1 s0 s1 c0 c1 a0 b0 a1 b1 | grant ack0 ack1 result0 result1 sr
        vt[0]  = mk(1,0,0,0,0,0,ADD,ADD,0,0,0,0,            2'b00,0,0,0,0,4'b0000);
        vt[1]  = mk(0,0,1,0,1,0,ADD,ADD,5,3,0,0,            2'b01,1,0,8,0,4'b0000);
        vt[2]  = mk(0,0,0,0,0,0,ADD,ADD,0,0,0,0,            2'b00,0,0,8,0,4'b0000);
        vt[3]  = mk(1,0,0,0,0,0,ADD,ADD,0,0,0,0,            2'b00,0,0,0,0,4'b0000);
        vt[4]  = mk(0,0,1,1,0,0,ADD,SUB,1,1,7,2,            2'b01,1,0,2,0,4'b0000);
        vt[5]  = mk(0,0,1,1,0,0,ADD,SUB,1,1,7,2,            2'b10,0,1,2,5,4'b0000);
        vt[6]  = mk(0,0,1,1,0,0,ADD,SUB,1,1,7,2,            2'b01,1,0,2,5,4'b0000);
        vt[7]  = mk(0,0,1,1,0,0,ADD,SUB,1,1,7,2,            2'b10,0,1,2,5,4'b0000);
        vt[8]  = mk(0,0,0,0,0,0,ADD,ADD,0,0,0,0,            2'b00,0,0,2,5,4'b0000);
        vt[9]  = mk(0,0,0,1,0,1,ADD,ADD,0,0,32'hFFFFFFFF,1, 2'b10,0,1,2,0,4'b1100);
        vt[10] = mk(0,0,1,0,0,0,ADC,ADD,0,0,0,0,            2'b01,1,0,1,0,4'b1100);
        vt[11] = mk(0,0,0,1,0,1,ADD,ADD,0,0,32'hFFFFFFFF,2, 2'b10,0,1,1,1,4'b0100);
        vt[12] = mk(0,0,1,0,0,0,SUB,ADD,1,1,0,0,            2'b01,1,0,0,1,4'b0100);
        vt[13] = mk(0,0,0,0,0,0,ADD,ADD,0,0,0,0,            2'b00,0,0,0,1,4'b0100);
        vt[14] = mk(0,1,1,0,0,0,ADD,ADD,10,20,0,0,          2'b00,0,0,0,1,4'b0100);
        vt[15] = mk(0,1,1,0,0,0,ADD,ADD,10,20,0,0,          2'b00,0,0,0,1,4'b0100);
        vt[16] = mk(0,0,1,0,0,0,ADD,ADD,10,20,0,0,          2'b01,1,0,30,1,4'b0100);
        vt[17] = mk(1,0,0,1,0,1,ADD,ADD,0,0,4,4,            2'b10,0,0,0,0,4'b0000);
        vt[18] = mk(0,0,1,1,0,0,ADD,SUB,1,1,7,2,            2'b01,1,0,2,0,4'b0000);

        rst = 1'b1; flush = 1'b0; req0 = 1'b0; req1 = 1'b0; s_0 = 1'b0; s_1 = 1'b0;
        val1_0 = 0; val2_0 = 0; val1_1 = 0; val2_1 = 0; cmd_0 = ADD; cmd_1 = ADD;
        repeat (2) @(posedge clk);
        #1;
        prev_sr = 4'b0000;

        for (int i = 0; i < 19; i++) begin
            rst = vt[i].rst; flush = vt[i].flush; req0 = vt[i].r0; req1 = vt[i].r1;
            s_0 = vt[i].s0; s_1 = vt[i].s1; cmd_0 = vt[i].c0; cmd_1 = vt[i].c1;
            val1_0 = vt[i].a0; val2_0 = vt[i].b0; val1_1 = vt[i].a1; val2_1 = vt[i].b1;
            #4;
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vt[i].eg));
            chk($sformatf("v%0d_cin", i), 32'(alu_cin), 32'(prev_sr[2]));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ack0", i), 32'(ack0), 32'(vt[i].ea0));
            chk($sformatf("v%0d_ack1", i), 32'(ack1), 32'(vt[i].ea1));
            chk($sformatf("v%0d_result0", i), result0, vt[i].er0);
            chk($sformatf("v%0d_result1", i), result1, vt[i].er1);
            chk($sformatf("v%0d_sr", i), 32'(sr), 32'(vt[i].esr));
            prev_sr = vt[i].esr;
        end

        // Randomized phase: requesters obey the hold-until-ack contract.
        rst = 1'b1; flush = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; m_ack[i] = 1'b0; m_res[i] = 32'd0;
            opc[i] = ADD; opa[i] = 0; opb[i] = 0; ops[i] = 1'b0;
        end
        m_sr = 4'b0000;
        m_ptr = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (m_ack[i]) begin
                    if ($urandom_range(0, 1) == 1) new_op(i);
                    else act[i] = 1'b0;
                end else if (!act[i] && $urandom_range(0, 1) == 1) begin
                    new_op(i);
                end
            end
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 7) == 0);
            req0 = act[0]; req1 = act[1];
            cmd_0 = opc[0]; cmd_1 = opc[1]; s_0 = ops[0]; s_1 = ops[1];
            val1_0 = opa[0]; val2_0 = opb[0]; val1_1 = opa[1]; val2_1 = opb[1];

            // Winner: preferred port if both eligible, else the sole eligible one.
            win = -1;
            if (!flush) begin
                if (act[0] && !m_ack[0] && act[1] && !m_ack[1]) win = m_ptr ? 1 : 0;
                else if (act[0] && !m_ack[0]) win = 0;
                else if (act[1] && !m_ack[1]) win = 1;
            end
            eg = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
            #4;
            chk("rnd_grant", 32'(grant), 32'(eg));
            chk("rnd_cin", 32'(alu_cin), 32'(m_sr[2]));
            @(posedge clk);
            #1;
            if (rst) begin
                m_ack[0] = 1'b0; m_ack[1] = 1'b0; m_res[0] = 0; m_res[1] = 0;
                m_sr = 4'b0000; m_ptr = 1'b0;
            end else begin
                m_ack[0] = (win == 0);
                m_ack[1] = (win == 1);
                if (win >= 0) begin
                    fr = alu_ref(opc[win], opa[win], opb[win], m_sr[2]);
                    m_res[win] = fr[31:0];
                    if (ops[win]) m_sr = fr[35:32];
                    m_ptr = (win == 0);
                end
            end
            chk("rnd_ack0", 32'(ack0), 32'(m_ack[0]));
            chk("rnd_ack1", 32'(ack1), 32'(m_ack[1]));
            chk("rnd_result0", result0, m_res[0]);
            chk("rnd_result1", result1, m_res[1]);
            chk("rnd_sr", 32'(sr), 32'(m_sr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
